alu_csr_bank: RTL

Parametrised APB-facing control/status register bank for the ALU subsystem. It holds the command fields (operation, ID, N operand words) and pushes one packed command into FIFO_IN per start request through a valid/full handshake. It autonomously pops FIFO_OUT into a held RESULT register and exposes sticky status plus a level interrupt. It integrates the APB slave decode that the previous register block left to external control logic.

---
 rtl/alu_csr_bank.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_csr_bank.sv
// APB control/status register bank for the ALU subsystem: builds commands for FIFO_IN,
// drains FIFO_OUT into a held RESULT register and raises a level interrupt.
module alu_csr_bank #(
    parameter int APB_BUS_SIZE   = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int ID_SIZE        = 8,
    parameter int OPERATION_SIZE = 2,
    parameter int NUM_OPERANDS   = 2,
    parameter int FIFO_OUT_WIDTH = 25,
    parameter int CMD_WIDTH      = NUM_OPERANDS*APB_BUS_SIZE+ID_SIZE+OPERATION_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDR_WIDTH-1:0]     paddr,
    input  logic [APB_BUS_SIZE-1:0]   pwdata,
    output logic [APB_BUS_SIZE-1:0]   prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      cmd_valid,
    input  logic                      fifo_in_full,
    output logic [CMD_WIDTH-1:0]      cmd_data,
    input  logic                      fifo_out_empty,
    output logic                      res_rd_en,
    input  logic [FIFO_OUT_WIDTH-1:0] res_data,
    output logic                      irq
);

    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] W_CTRL   = WORD_W'(0);
    localparam logic [WORD_W-1:0] W_STATUS = WORD_W'(1);
    localparam logic [WORD_W-1:0] W_RESULT = WORD_W'(2);
    localparam logic [WORD_W-1:0] W_IRQCLR = WORD_W'(3);
    localparam logic [WORD_W-1:0] W_DATA0  = WORD_W'(4);
    localparam logic [WORD_W-1:0] W_DLAST  = WORD_W'(4 + NUM_OPERANDS - 1);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_POP  = 2'd1,
        R_CAP  = 2'd2,
        R_HOLD = 2'd3
    } res_state_e;

    logic [OPERATION_SIZE-1:0]                    op_q, op_d;
    logic [ID_SIZE-1:0]                           id_q, id_d;
    logic                                         irq_en_q, irq_en_d;
    logic                                         auto_start_q, auto_start_d;
    logic [NUM_OPERANDS-1:0][APB_BUS_SIZE-1:0]    data_q, data_d;
    logic                                         cmd_pending_q, cmd_pending_d;
    logic                                         overflow_q, overflow_d;
    logic [FIFO_OUT_WIDTH-1:0]                    result_q;
    logic                                         result_valid_q;
    logic                                         res_rd_en_q;
    logic                                         irq_q;
    res_state_e                                   state_q;

    logic [WORD_W-1:0]       word_s;
    logic                    access_s, wr_s, rd_s;
    logic                    is_data_s, mapped_s, err_s, wr_ok_s;
    logic                    wr_ctrl_ok_s, start_req_s, result_rd_ok_s;
    logic [APB_BUS_SIZE-1:0] rdata_s;
    logic                    unused_paddr_s;

    assign word_s         = paddr[ADDR_WIDTH-1:2];
    assign unused_paddr_s = ^paddr[1:0];
    assign access_s       = psel & penable;
    assign wr_s           = access_s & pwrite;
    assign rd_s           = access_s & ~pwrite;
    assign is_data_s      = (word_s >= W_DATA0) && (word_s <= W_DLAST);
    assign mapped_s       = (word_s <= W_IRQCLR) || is_data_s;

    // Transfer error: unmapped, RO write, config write while a command waits, empty RESULT read.
    always_comb begin
        err_s = 1'b0;
        if (!mapped_s) begin
            err_s = 1'b1;
        end else if (wr_s && ((word_s == W_STATUS) || (word_s == W_RESULT))) begin
            err_s = 1'b1;
        end else if (wr_s && ((word_s == W_CTRL) || is_data_s) && cmd_pending_q) begin
            err_s = 1'b1;
        end else if (rd_s && (word_s == W_RESULT) && !result_valid_q) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    assign wr_ok_s        = wr_s & ~err_s;
    assign wr_ctrl_ok_s   = wr_ok_s & (word_s == W_CTRL);
    assign result_rd_ok_s = rd_s & ~err_s & (word_s == W_RESULT);
    // A start request is recognised even when rejected so it can flag overflow.
    assign start_req_s    = wr_s & (((word_s == W_CTRL) & pwdata[0]) |
                                    (auto_start_q & (word_s == W_DLAST)));

    assign op_d         = wr_ctrl_ok_s ? pwdata[1 +: OPERATION_SIZE] : op_q;
    assign id_d         = wr_ctrl_ok_s ? pwdata[8 +: ID_SIZE]        : id_q;
    assign irq_en_d     = wr_ctrl_ok_s ? pwdata[16]                  : irq_en_q;
    assign auto_start_d = wr_ctrl_ok_s ? pwdata[17]                  : auto_start_q;

    // Operand register next state.
    always_comb begin
        data_d = data_q;
        for (int k = 0; k < NUM_OPERANDS; k++) begin
            if (wr_ok_s && (word_s == W_DATA0 + WORD_W'(k))) begin
                data_d[k] = pwdata;
            end else begin
                data_d[k] = data_q[k];
            end
        end
    end

    // Pending command and sticky overflow; a new overflow outranks a same-cycle clear.
    always_comb begin
        cmd_pending_d = cmd_pending_q;
        overflow_d    = overflow_q;
        if (start_req_s && !cmd_pending_q) begin
            cmd_pending_d = 1'b1;
        end else if (cmd_pending_q && !fifo_in_full) begin
            cmd_pending_d = 1'b0;
        end else begin
            cmd_pending_d = cmd_pending_q;
        end
        if (start_req_s && cmd_pending_q) begin
            overflow_d = 1'b1;
        end else if (wr_ok_s && (word_s == W_IRQCLR) && pwdata[0]) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Read data mux; errored and idle transfers return zero.
    always_comb begin
        rdata_s = '0;
        case (word_s)
            W_CTRL: begin
                rdata_s[1 +: OPERATION_SIZE] = op_q;
                rdata_s[8 +: ID_SIZE]        = id_q;
                rdata_s[16]                  = irq_en_q;
                rdata_s[17]                  = auto_start_q;
            end
            W_STATUS: begin
                rdata_s[5:0] = {irq_q, overflow_q, result_valid_q, cmd_pending_q,
                                fifo_out_empty, fifo_in_full};
            end
            W_RESULT: begin
                rdata_s[FIFO_OUT_WIDTH-1:0] = result_q;
            end
            default: begin
                for (int k = 0; k < NUM_OPERANDS; k++) begin
                    if (word_s == W_DATA0 + WORD_W'(k)) begin
                        rdata_s = data_q[k];
                    end else begin
                        rdata_s = rdata_s;
                    end
                end
            end
        endcase
        if (rd_s && !err_s) begin
            prdata = rdata_s;
        end else begin
            prdata = '0;
        end
    end

    // Command/configuration registers and registered interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= '0;
            id_q          <= '0;
            irq_en_q      <= 1'b0;
            auto_start_q  <= 1'b0;
            data_q        <= '0;
            cmd_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            op_q          <= op_d;
            id_q          <= id_d;
            irq_en_q      <= irq_en_d;
            auto_start_q  <= auto_start_d;
            data_q        <= data_d;
            cmd_pending_q <= cmd_pending_d;
            overflow_q    <= overflow_d;
            irq_q         <= irq_en_q & (result_valid_q | overflow_q);
        end
    end

    // Result FSM: pop FIFO_OUT once, capture the head, hold it until software reads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= R_IDLE;
            res_rd_en_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (!result_valid_q && !fifo_out_empty) begin
                        state_q     <= R_POP;
                        res_rd_en_q <= 1'b1;
                    end else begin
                        state_q     <= R_IDLE;
                        res_rd_en_q <= 1'b0;
                    end
                end
                R_POP: begin
                    state_q     <= R_CAP;
                    res_rd_en_q <= 1'b0;
                end
                R_CAP: begin
                    result_q       <= res_data;
                    result_valid_q <= 1'b1;
                    state_q        <= R_HOLD;
                    res_rd_en_q    <= 1'b0;
                end
                R_HOLD: begin
                    res_rd_en_q <= 1'b0;
                    if (result_rd_ok_s) begin
                        result_valid_q <= 1'b0;
                        state_q        <= R_IDLE;
                    end else begin
                        state_q <= R_HOLD;
                    end
                end
                default: begin
                    state_q     <= R_IDLE;
                    res_rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign pready    = 1'b1;
    assign pslverr   = access_s & err_s;
    assign cmd_valid = cmd_pending_q;
    assign cmd_data  = {data_q, id_q, op_q};
    assign res_rd_en = res_rd_en_q;
    assign irq       = irq_q;

endmodule
